// File: rtl/id_issue_unit_if.sv
// Fetch-side and issue-side signals of the decode/issue stage.
// The slave modport is the stage itself; the master modport is the environment
// around it (the fetch unit plus the ID/EX boundary).
interface id_issue_unit_if #(
    parameter int CNT_W = 16
);
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_inst;
    logic [15:0]      if_pc;
    logic             ex_ready;
    logic             id_valid;
    logic [2:0]       id_opcode;
    logic [4:0]       id_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [15:0]      id_pc;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             illegal;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output if_valid, if_inst, if_pc, ex_ready,
        input  if_ready, id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_pc,
               fwd_a, fwd_b, illegal, stall_cnt
    );

    modport slave (
        input  if_valid, if_inst, if_pc, ex_ready,
        output if_ready, id_valid, id_opcode, id_rd, id_rs1, id_rs2, id_pc,
               fwd_a, fwd_b, illegal, stall_cnt
    );
endinterface

// File: rtl/id_issue_unit.sv
// Decode-and-issue stage. Holds one fetched word in the decode register (D),
// issues it into the issue register (E) with forwarding selects, and remembers
// the destination of the instruction issued one advance earlier (M). With
// FWD_EN=0, read-after-write hazards against E or M stall D and insert bubbles.
module id_issue_unit #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    id_issue_unit_if.slave bus
);
    // Decode register
    logic        d_valid;
    logic [31:0] d_inst;
    logic [15:0] d_pc;

    // Issue register
    logic        e_valid;
    logic [2:0]  e_opcode;
    logic [4:0]  e_rd;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [15:0] e_pc;
    logic [1:0]  e_fwd_a;
    logic [1:0]  e_fwd_b;
    logic        e_illegal;

    // Shadow of the previously issued slot; m_prod is set only for a real producer
    logic        m_prod;
    logic [4:0]  m_rd;

    logic [CNT_W-1:0] stall_cnt;

    // Decoded view of D
    logic        d_illegal;
    logic [2:0]  d_opcode;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;

    // Hazard and handshake terms
    logic        e_prod;
    logic        match_e_a;
    logic        match_m_a;
    logic        match_e_b;
    logic        match_m_b;
    logic        stall;
    logic        issue;
    logic        ready;
    logic        accept;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;

    // Split the decode word into fields; an illegal word becomes an all-zero NOP so it never reads or writes
    always_comb begin
        d_illegal = d_inst[31] || (d_inst[30:15] > 16'd4);
        d_opcode  = 3'd0;
        d_rd      = 5'd0;
        d_rs1     = 5'd0;
        d_rs2     = 5'd0;
        if (!d_illegal) begin
            d_opcode = d_inst[17:15];
            d_rd     = d_inst[14:10];
            d_rs1    = d_inst[9:5];
            d_rs2    = d_inst[4:0];
        end
    end

    // Compare D sources against the two older slots (E youngest) and derive stall, issue and handshake
    always_comb begin
        e_prod    = e_valid && (e_opcode != 3'd0) && (e_rd != 5'd0);
        match_e_a = (d_rs1 != 5'd0) && e_prod && (d_rs1 == e_rd);
        match_m_a = (d_rs1 != 5'd0) && m_prod && (d_rs1 == m_rd);
        match_e_b = (d_rs2 != 5'd0) && e_prod && (d_rs2 == e_rd);
        match_m_b = (d_rs2 != 5'd0) && m_prod && (d_rs2 == m_rd);
        stall     = !FWD_EN && d_valid && (match_e_a || match_m_a || match_e_b || match_m_b);
        issue     = bus.ex_ready && d_valid && !stall;
        ready     = rst_n && (!d_valid || (bus.ex_ready && !stall));
        accept    = bus.if_valid && ready;
        sel_a     = 2'd0;
        sel_b     = 2'd0;
        if (FWD_EN) begin
            if (match_e_a)      sel_a = 2'd1;
            else if (match_m_a) sel_a = 2'd2;
            if (match_e_b)      sel_b = 2'd1;
            else if (match_m_b) sel_b = 2'd2;
        end
    end

    // Decode register: refill on every accepted word, empty once its instruction issues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_valid <= 1'b0;
            d_inst  <= 32'd0;
            d_pc    <= 16'd0;
        end else if (accept) begin
            d_valid <= 1'b1;
            d_inst  <= bus.if_inst;
            d_pc    <= bus.if_pc;
        end else if (issue) begin
            d_valid <= 1'b0;
        end
    end

    // Issue and shadow registers: shift on advance, hold when frozen (illegal drops after its one cycle)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_valid   <= 1'b0;
            e_opcode  <= 3'd0;
            e_rd      <= 5'd0;
            e_rs1     <= 5'd0;
            e_rs2     <= 5'd0;
            e_pc      <= 16'd0;
            e_fwd_a   <= 2'd0;
            e_fwd_b   <= 2'd0;
            e_illegal <= 1'b0;
            m_prod    <= 1'b0;
            m_rd      <= 5'd0;
        end else if (bus.ex_ready) begin
            m_prod <= e_prod;
            m_rd   <= e_rd;
            if (issue) begin
                e_valid   <= 1'b1;
                e_opcode  <= d_opcode;
                e_rd      <= d_rd;
                e_rs1     <= d_rs1;
                e_rs2     <= d_rs2;
                e_pc      <= d_pc;
                e_fwd_a   <= sel_a;
                e_fwd_b   <= sel_b;
                e_illegal <= d_illegal;
            end else begin
                e_valid   <= 1'b0;
                e_opcode  <= 3'd0;
                e_rd      <= 5'd0;
                e_rs1     <= 5'd0;
                e_rs2     <= 5'd0;
                e_pc      <= 16'd0;
                e_fwd_a   <= 2'd0;
                e_fwd_b   <= 2'd0;
                e_illegal <= 1'b0;
            end
        end else begin
            e_illegal <= 1'b0;
        end
    end

    // Stall counter: counts advancing cycles spent stalled, sticks at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.ex_ready && stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.if_ready  = ready;
    assign bus.id_valid  = e_valid;
    assign bus.id_opcode = e_opcode;
    assign bus.id_rd     = e_rd;
    assign bus.id_rs1    = e_rs1;
    assign bus.id_rs2    = e_rs2;
    assign bus.id_pc     = e_pc;
    assign bus.fwd_a     = e_fwd_a;
    assign bus.fwd_b     = e_fwd_b;
    assign bus.illegal   = e_illegal;
    assign bus.stall_cnt = stall_cnt;
endmodule
